// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with store lane steering and alignment check
// Captures EX results, builds byte enables / replicated store data, and squashes misaligned accesses.
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic              Zero_in,
  input  logic [DATA_W-1:0] RtData_in,
  input  logic [4:0]        WriteReg_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic              Branch_in,
  input  logic [1:0]        MemSize_in,
  input  logic [DATA_W-1:0] BranchTarget_in,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [4:0]        WriteReg_out,
  output logic              RegWrite_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              MemToReg_out,
  output logic [1:0]        MemSize_out,
  output logic [DATA_W-1:0] StoreData_out,
  output logic [3:0]        ByteEn_out,
  output logic              PCSrc_out,
  output logic [DATA_W-1:0] BranchTarget_out,
  output logic              Valid_out,
  output logic              Misaligned_out
);

  logic [DATA_W-1:0] r_alu_result;
  logic [4:0]        r_write_reg;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic [1:0]        r_mem_size;
  logic [DATA_W-1:0] r_store_data;
  logic [3:0]        r_byte_en;
  logic              r_pcsrc;
  logic [DATA_W-1:0] r_branch_target;
  logic              r_valid;
  logic              r_misaligned;

  logic              w_mem_acc;
  logic              w_is_half;
  logic              w_is_byte;
  logic              w_misalign;
  logic [DATA_W-1:0] w_store_data;
  logic [3:0]        w_byte_en;
  logic              w_pcsrc;
  logic              w_bubble;

  always_comb begin
    w_mem_acc    = MemRead_in | MemWrite_in;
    w_is_half    = (MemSize_in == 2'b01);
    w_is_byte    = (MemSize_in == 2'b10);
    w_misalign   = 1'b0;
    w_store_data = RtData_in;
    w_byte_en    = 4'b1111;
    // Size code 11 falls through to word handling.
    if (w_is_byte) begin
      w_store_data = {4{RtData_in[7:0]}};
      w_byte_en    = 4'b0001 << ALUResult_in[1:0];
    end else if (w_is_half) begin
      w_store_data = {2{RtData_in[15:0]}};
      w_byte_en    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
      w_misalign   = w_mem_acc & ALUResult_in[0];
    end else begin
      w_misalign   = w_mem_acc & (ALUResult_in[1:0] != 2'b00);
    end
    if (!w_mem_acc || w_misalign) begin
      w_byte_en = 4'b0000;
    end
    w_pcsrc  = Branch_in & Zero_in & Valid_in;
    w_bubble = Flush | (~Stall & ~Valid_in);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset || w_bubble) begin
      r_alu_result    <= '0;
      r_write_reg     <= '0;
      r_reg_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_mem_size      <= '0;
      r_store_data    <= '0;
      r_byte_en       <= '0;
      r_pcsrc         <= 1'b0;
      r_branch_target <= '0;
      r_valid         <= 1'b0;
      r_misaligned    <= 1'b0;
    end else if (!Stall) begin
      r_alu_result    <= ALUResult_in;
      r_write_reg     <= WriteReg_in;
      r_reg_write     <= RegWrite_in & (WriteReg_in != 5'd0) & ~w_misalign;
      r_mem_read      <= MemRead_in & ~w_misalign;
      r_mem_write     <= MemWrite_in & ~w_misalign;
      r_mem_to_reg    <= MemToReg_in;
      r_mem_size      <= MemSize_in;
      r_store_data    <= w_store_data;
      r_byte_en       <= w_byte_en;
      r_pcsrc         <= w_pcsrc;
      // Target is only meaningful when taken; keep the last taken target otherwise.
      if (w_pcsrc) begin
        r_branch_target <= BranchTarget_in;
      end
      r_valid         <= 1'b1;
      r_misaligned    <= w_misalign;
    end
  end

  assign ALUResult_out    = r_alu_result;
  assign WriteReg_out     = r_write_reg;
  assign RegWrite_out     = r_reg_write;
  assign MemRead_out      = r_mem_read;
  assign MemWrite_out     = r_mem_write;
  assign MemToReg_out     = r_mem_to_reg;
  assign MemSize_out      = r_mem_size;
  assign StoreData_out    = r_store_data;
  assign ByteEn_out       = r_byte_en;
  assign PCSrc_out        = r_pcsrc;
  assign BranchTarget_out = r_branch_target;
  assign Valid_out        = r_valid;
  assign Misaligned_out   = r_misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        Valid_in = 1'b0;
  logic [31:0] ALUResult_in = '0;
  logic        Zero_in = 1'b0;
  logic [31:0] RtData_in = '0;
  logic [4:0]  WriteReg_in = '0;
  logic        RegWrite_in = 1'b0;
  logic        MemRead_in = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic        MemToReg_in = 1'b0;
  logic        Branch_in = 1'b0;
  logic [1:0]  MemSize_in = '0;
  logic [31:0] BranchTarget_in = '0;

  logic [31:0] ALUResult_out;
  logic [4:0]  WriteReg_out;
  logic        RegWrite_out;
  logic        MemRead_out;
  logic        MemWrite_out;
  logic        MemToReg_out;
  logic [1:0]  MemSize_out;
  logic [31:0] StoreData_out;
  logic [3:0]  ByteEn_out;
  logic        PCSrc_out;
  logic [31:0] BranchTarget_out;
  logic        Valid_out;
  logic        Misaligned_out;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
    .ALUResult_in(ALUResult_in), .Zero_in(Zero_in), .RtData_in(RtData_in),
    .WriteReg_in(WriteReg_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in), .Branch_in(Branch_in),
    .MemSize_in(MemSize_in), .BranchTarget_in(BranchTarget_in),
    .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
    .MemSize_out(MemSize_out), .StoreData_out(StoreData_out), .ByteEn_out(ByteEn_out),
    .PCSrc_out(PCSrc_out), .BranchTarget_out(BranchTarget_out), .Valid_out(Valid_out),
    .Misaligned_out(Misaligned_out)
  );

  always #5 Clk = ~Clk;

  logic [113:0] all_out;
  assign all_out = {ALUResult_out, WriteReg_out, RegWrite_out, MemRead_out, MemWrite_out,
                    MemToReg_out, MemSize_out, StoreData_out, ByteEn_out, PCSrc_out,
                    BranchTarget_out, Valid_out, Misaligned_out};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                    input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                    input logic m2r, input logic br, input logic z, input logic [1:0] sz,
                    input logic [31:0] tgt);
    Valid_in = v; ALUResult_in = alu; RtData_in = rt; WriteReg_in = wr;
    RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemToReg_in = m2r;
    Branch_in = br; Zero_in = z; MemSize_in = sz; BranchTarget_in = tgt;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1 Reset = 1'b0;
    #1 check("reset_async_zero", 128'(all_out), 128'd0);
    op(1, 32'h1003, 32'hAABBCCDD, 5'd0, 0, 0, 1, 0, 0, 0, 2'b10, 32'h0);
    step();
    check("reset_held_over_edge", 128'(all_out), 128'd0);
    #2 Reset = 1'b1;

    // sb to lane 3
    step();
    check("sb_store_data", 128'(StoreData_out), 128'(32'hDDDDDDDD));
    check("sb_byte_en", 128'(ByteEn_out), 128'(4'b1000));
    check("sb_misaligned", 128'(Misaligned_out), 128'd0);
    check("sb_mem_write", 128'(MemWrite_out), 128'd1);
    check("sb_valid", 128'(Valid_out), 128'd1);
    check("sb_size", 128'(MemSize_out), 128'(2'b10));

    // sh upper half, then misaligned sh
    op(1, 32'h1002, 32'h11223344, 5'd0, 0, 0, 1, 0, 0, 0, 2'b01, 32'h0);
    step();
    check("sh_store_data", 128'(StoreData_out), 128'(32'h33443344));
    check("sh_byte_en", 128'(ByteEn_out), 128'(4'b1100));
    op(1, 32'h1001, 32'h11223344, 5'd0, 0, 0, 1, 0, 0, 0, 2'b01, 32'h0);
    step();
    check("sh_odd_misaligned", 128'(Misaligned_out), 128'd1);
    check("sh_odd_mem_write", 128'(MemWrite_out), 128'd0);
    check("sh_odd_byte_en", 128'(ByteEn_out), 128'd0);
    check("sh_odd_alu", 128'(ALUResult_out), 128'(32'h1001));

    // sw, then size 11 treated as word
    op(1, 32'h1000, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 32'h0);
    step();
    check("sw_store_data", 128'(StoreData_out), 128'(32'hCAFEF00D));
    check("sw_byte_en", 128'(ByteEn_out), 128'(4'b1111));
    op(1, 32'h1004, 32'h0, 5'd9, 1, 1, 0, 1, 0, 0, 2'b11, 32'h0);
    step();
    check("size11_byte_en", 128'(ByteEn_out), 128'(4'b1111));
    check("size11_regwrite", 128'(RegWrite_out), 128'd1);

    // misaligned lw
    op(1, 32'h1002, 32'h0, 5'd5, 1, 1, 0, 1, 0, 0, 2'b00, 32'h0);
    step();
    check("lw_mis_flag", 128'(Misaligned_out), 128'd1);
    check("lw_mis_memread", 128'(MemRead_out), 128'd0);
    check("lw_mis_regwrite", 128'(RegWrite_out), 128'd0);
    check("lw_mis_byte_en", 128'(ByteEn_out), 128'd0);
    check("lw_mis_wreg", 128'(WriteReg_out), 128'd5);
    check("lw_mis_mem2reg", 128'(MemToReg_out), 128'd1);

    // unaligned ALU result without memory access is not a fault
    op(1, 32'h3, 32'h0, 5'd3, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    step();
    check("nomem_misaligned", 128'(Misaligned_out), 128'd0);
    check("nomem_byte_en", 128'(ByteEn_out), 128'd0);
    check("nomem_regwrite", 128'(RegWrite_out), 128'd1);

    // beq taken, then not taken
    op(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 2'b00, 32'h40);
    step();
    check("beq_taken_pcsrc", 128'(PCSrc_out), 128'd1);
    check("beq_taken_target", 128'(BranchTarget_out), 128'(32'h40));
    op(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 2'b00, 32'h80);
    step();
    check("beq_nt_pcsrc", 128'(PCSrc_out), 128'd0);
    check("beq_nt_target_held", 128'(BranchTarget_out), 128'(32'h40));

    // write to r0 suppressed
    op(1, 32'h77, 32'h0, 5'd0, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    step();
    check("r0_regwrite", 128'(RegWrite_out), 128'd0);
    check("r0_alu", 128'(ALUResult_out), 128'(32'h77));

    // add then stall 3 cycles with changing inputs
    op(1, 32'd5, 32'h0, 5'd8, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    step();
    check("add_alu", 128'(ALUResult_out), 128'd5);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(1, 32'd100 + i, 32'h0, 5'd20 + 5'(i), 1, 1, 1, 0, 1, 1, 2'b10, 32'h500);
      step();
      check("stall_alu", 128'(ALUResult_out), 128'd5);
      check("stall_wreg", 128'(WriteReg_out), 128'd8);
      check("stall_pcsrc", 128'(PCSrc_out), 128'd0);
    end
    Flush = 1'b1;
    step();
    check("stall_flush_bubble", 128'(all_out), 128'd0);
    Stall = 1'b0;
    Flush = 1'b0;

    // Valid_in=0 bubble clears a previously taken target
    op(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 2'b00, 32'h100);
    step();
    check("taken_100_target", 128'(BranchTarget_out), 128'(32'h100));
    op(0, 32'h1234, 32'h5678, 5'd7, 1, 1, 0, 1, 1, 1, 2'b00, 32'h200);
    step();
    check("invalid_bubble", 128'(all_out), 128'd0);

    // async reset mid-stall, first load right after release
    op(1, 32'h2000, 32'h0, 5'd4, 1, 1, 0, 1, 0, 0, 2'b00, 32'h0);
    step();
    check("pre_reset_valid", 128'(Valid_out), 128'd1);
    Stall = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("midcycle_reset_zero", 128'(all_out), 128'd0);
    Stall = 1'b0;
    op(1, 32'h2004, 32'h0, 5'd6, 1, 1, 0, 1, 0, 0, 2'b00, 32'h0);
    #2 Reset = 1'b1;
    step();
    check("post_reset_alu", 128'(ALUResult_out), 128'(32'h2004));
    check("post_reset_wreg", 128'(WriteReg_out), 128'd6);
    check("post_reset_byte_en", 128'(ByteEn_out), 128'(4'b1111));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
